// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, synchronises the rows,
// classifies each full sweep and debounces it into one key event per physical press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SWEEPS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SWEEPS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      4'hF: code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  logic [3:0]       row_meta_reg;
  logic [3:0]       row_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       col_idx_reg;
  logic [3:0]       col_n_reg;
  logic [1:0]       acc_cnt_reg;
  logic [3:0]       acc_code_reg;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       cand_reg;
  logic [3:0]       cand_next;
  logic [3:0]       key_value_reg;
  logic             key_valid_reg;
  logic             key_down_reg;

  logic             sample_tick;
  logic             sweep_done;
  logic [3:0]       hit;
  logic [3:0]       row_code [4];
  logic [2:0]       col_cnt;
  logic [3:0]       sel_code;
  logic [2:0]       total_cnt;
  logic [1:0]       sweep_cnt;
  logic [3:0]       sweep_code;
  logic [1:0]       sweep_res;
  logic             accept;
  logic             release_done;

  // Rows are asynchronous to clk; nothing downstream sees row_n directly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_meta_reg <= 4'b1111;
      row_sync_reg <= 4'b1111;
    end else begin
      row_meta_reg <= row_n;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign sample_tick = (div_cnt_reg == DIV_LAST);
  assign sweep_done  = sample_tick && (col_idx_reg == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt_reg <= '0;
      col_idx_reg <= 2'd0;
      col_n_reg   <= 4'b1110;
    end else if (sample_tick) begin
      div_cnt_reg <= '0;
      col_idx_reg <= col_idx_reg + 2'd1;
      col_n_reg   <= {col_n_reg[2:0], col_n_reg[3]};
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_ONE;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign hit[gi]      = ~row_sync_reg[gi];
      assign row_code[gi] = key_code(2'(gi), col_idx_reg);
    end
  endgenerate

  always_comb begin
    col_cnt  = 3'd0;
    sel_code = 4'd0;
    for (int r = 3; r >= 0; r--) begin
      col_cnt = col_cnt + {2'b00, hit[r]};
      if (hit[r]) sel_code = row_code[r];
    end
  end

  // Key count saturates at two: beyond "more than one" the exact number is irrelevant.
  always_comb begin
    total_cnt  = {1'b0, acc_cnt_reg} + col_cnt;
    sweep_cnt  = (total_cnt >= 3'd2) ? 2'd2 : total_cnt[1:0];
    sweep_code = (acc_cnt_reg == 2'd1) ? acc_code_reg : sel_code;
    case (sweep_cnt)
      2'd0:    sweep_res = RES_NONE;
      2'd1:    sweep_res = RES_SINGLE;
      default: sweep_res = RES_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_cnt_reg  <= 2'd0;
      acc_code_reg <= 4'd0;
    end else if (sweep_done) begin
      acc_cnt_reg  <= 2'd0;
      acc_code_reg <= 4'd0;
    end else if (sample_tick) begin
      acc_cnt_reg  <= sweep_cnt;
      acc_code_reg <= sweep_code;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cand_next    = cand_reg;
    accept       = 1'b0;
    release_done = 1'b0;
    if (sweep_done) begin
      case (state_reg)
        ST_IDLE: begin
          if (sweep_res == RES_SINGLE) begin
            cand_next = sweep_code;
            cnt_next  = CNT_ONE;
            if (DEBOUNCE_SWEEPS == 1) accept = 1'b1;
            else state_next = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (sweep_res == RES_SINGLE) begin
            if (sweep_code == cand_reg) begin
              cnt_next = cnt_reg + CNT_ONE;
              if (cnt_reg + CNT_ONE == CNT_TARGET) accept = 1'b1;
            end else begin
              cand_next = sweep_code;
              cnt_next  = CNT_ONE;
            end
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end
        ST_PRESSED: begin
          if (sweep_res == RES_NONE) begin
            if (DEBOUNCE_SWEEPS == 1) begin
              release_done = 1'b1;
              state_next   = ST_IDLE;
              cnt_next     = '0;
            end else begin
              state_next = ST_RELEASE;
              cnt_next   = CNT_ONE;
            end
          end
        end
        default: begin
          if (sweep_res == RES_NONE) begin
            if (cnt_reg + CNT_ONE == CNT_TARGET) begin
              release_done = 1'b1;
              state_next   = ST_IDLE;
              cnt_next     = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end else begin
            state_next = ST_PRESSED;
          end
        end
      endcase
      if (accept) begin
        state_next = ST_PRESSED;
        cnt_next   = '0;
      end
    end
  end

  // Accepts only happen on sweep boundaries, so key_valid can never fire twice in a row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      cand_reg      <= 4'd0;
      key_value_reg <= 4'd0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cand_reg      <= cand_next;
      key_valid_reg <= accept;
      if (accept) begin
        key_value_reg <= cand_next;
        key_down_reg  <= 1'b1;
      end else if (release_done) begin
        key_down_reg  <= 1'b0;
      end
    end
  end

  assign col_n     = col_n_reg;
  assign key_value = key_value_reg;
  assign key_valid = key_valid_reg;
  assign key_down  = key_down_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model, a sweep-level run-length reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 3;
  localparam int SWEEP    = 4 * SCAN_DIV;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_down;
  logic [15:0] keys = '0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;

  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int         m_edges;
  int         run_code;
  int         run_len;
  int         none_len;
  logic       m_down;
  logic       m_valid;
  logic [3:0] m_value;
  logic [3:0] m_col;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SWEEPS(DS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_value (key_value),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  // Pressed key (r,c) shorts row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges  = 0;
    run_code = -1;
    run_len  = 0;
    none_len = 0;
    m_down   = 1'b0;
    m_valid  = 1'b0;
    m_value  = 4'd0;
    m_col    = 4'b1110;
  endtask

  // A press is accepted after DS identical single-key sweeps; a release after DS empty sweeps.
  task automatic model_step();
    int n;
    int code;
    n = 0;
    code = 0;
    m_valid = 1'b0;
    if (m_edges % SWEEP == SWEEP - 1) begin
      for (int i = 0; i < 16; i++)
        if (keys[i]) begin
          n++;
          code = keymap[i];
        end
      if (n == 1) begin
        if (run_code == code) run_len++;
        else begin
          run_code = code;
          run_len  = 1;
        end
        none_len = 0;
      end else if (n == 0) begin
        run_len = 0;
        none_len++;
      end else begin
        run_len  = 0;
        none_len = 0;
      end
      if (!m_down && n == 1 && run_len == DS) begin
        m_valid = 1'b1;
        m_value = 4'(code);
        m_down  = 1'b1;
      end else if (m_down && n == 0 && none_len == DS) begin
        m_down = 1'b0;
      end
    end
    m_edges++;
    m_col = 4'hF;
    m_col[(m_edges / SCAN_DIV) % 4] = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      check("key_value", key_value, m_value);
      check("key_down", {3'b0, key_down}, {3'b0, m_down});
      check("col_n", col_n, m_col);
      check("valid_back_to_back", {3'b0, key_valid & prev_valid}, 4'd0);
      if (key_valid) begin
        pulses++;
        $display("key event: value=%0d at %0t", key_value, $time);
      end
      prev_valid = key_valid;
    end
  end

  task automatic sweeps(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      while (m_edges % SWEEP != 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [3:0] col_seq [4];
    col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // 1: reset values and column rotation
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_value", key_value, 4'd0);
    check("rst_key_valid", {3'b0, key_valid}, 4'd0);
    check("rst_key_down", {3'b0, key_down}, 4'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("col_sequence", col_n, col_seq[i/4]);
    end
    sweeps(1);
    $display("step 1: reset and column scan done at %0t", $time);

    // 2: hold A, then release
    keys = 16'd0;
    keys[3] = 1'b1;
    sweeps(2);
    check("A_not_yet", 4'(pulses), 4'd0);
    sweeps(1);
    check("A_valid", {3'b0, key_valid}, 4'd1);
    check("A_value", key_value, 4'd10);
    sweeps(2);
    check("A_pulses", 4'(pulses), 4'd1);
    check("A_down", {3'b0, key_down}, 4'd1);
    keys = 16'd0;
    sweeps(2);
    check("A_down_hold", {3'b0, key_down}, 4'd1);
    sweeps(1);
    check("A_released", {3'b0, key_down}, 4'd0);
    $display("step 2: press/release A done at %0t", $time);

    // 3: one-sweep glitch on 8
    keys[9] = 1'b1;
    sweeps(1);
    keys = 16'd0;
    sweeps(3);
    check("glitch_pulses", 4'(pulses), 4'd1);
    check("glitch_value", key_value, 4'd10);
    check("glitch_down", {3'b0, key_down}, 4'd0);
    $display("step 3: glitch rejected at %0t", $time);

    // 4: 5+6 together, then 5 alone
    keys[5] = 1'b1;
    keys[6] = 1'b1;
    sweeps(4);
    check("multi_pulses", 4'(pulses), 4'd1);
    check("multi_down", {3'b0, key_down}, 4'd0);
    keys[6] = 1'b0;
    sweeps(2);
    check("five_not_yet", key_value, 4'd10);
    sweeps(1);
    check("five_valid", {3'b0, key_valid}, 4'd1);
    check("five_value", key_value, 4'd5);
    keys = 16'd0;
    sweeps(3);
    check("five_pulses", 4'(pulses), 4'd2);
    check("five_released", {3'b0, key_down}, 4'd0);
    $display("step 4: multi-key then 5 done at %0t", $time);

    // 5: release bounce on #
    keys[14] = 1'b1;
    sweeps(3);
    check("hash_value", key_value, 4'd15);
    for (int i = 0; i < 4; i++) begin
      keys = 16'd0;
      sweeps(1);
      check("bounce_down", {3'b0, key_down}, 4'd1);
      keys[14] = 1'b1;
      sweeps(1);
    end
    keys = 16'd0;
    sweeps(2);
    check("bounce_down_hold", {3'b0, key_down}, 4'd1);
    sweeps(1);
    check("bounce_released", {3'b0, key_down}, 4'd0);
    check("bounce_pulses", 4'(pulses), 4'd3);
    $display("step 5: release bounce done at %0t", $time);

    // 6: reset while 0 is held
    keys[13] = 1'b1;
    sweeps(4);
    check("zero_pulses", 4'(pulses), 4'd4);
    check("zero_down", {3'b0, key_down}, 4'd1);
    check("zero_value", key_value, 4'd0);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    check("midrst_down", {3'b0, key_down}, 4'd0);
    check("midrst_col_n", col_n, 4'b1110);
    check("midrst_valid", {3'b0, key_valid}, 4'd0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    sweeps(2);
    check("rearm_not_yet", {3'b0, key_down}, 4'd0);
    check("rearm_pulses_pending", 4'(pulses), 4'd4);
    sweeps(1);
    check("rearm_valid", {3'b0, key_valid}, 4'd1);
    check("rearm_value", key_value, 4'd0);
    sweeps(1);
    check("rearm_pulses", 4'(pulses), 4'd5);
    check("rearm_down", {3'b0, key_down}, 4'd1);
    keys = 16'd0;
    sweeps(3);
    check("final_released", {3'b0, key_down}, 4'd0);
    $display("step 6: reset mid-press done at %0t", $time);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
